// File: rtl/rally_sequencer_pkg.sv
// Shared definitions for the rally sequencer: internal FSM states, the
// 2-bit external state codes, serve directions, score width and a couple
// of elaboration-time helpers.
package rally_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_RALLY = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } seq_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_RALLY = 2'd2;
    localparam logic [1:0] ST_POINT = 2'd3;

    localparam logic DIR_P1 = 1'b0;
    localparam logic DIR_P2 = 1'b1;

    localparam int SCORE_W = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // OVER has no code of its own; it shares POINT's code and is told
    // apart by game_over.
    function automatic logic [1:0] state_code(input seq_state_t s);
        logic [1:0] code;
        case (s)
            S_IDLE:  code = ST_IDLE;
            S_SERVE: code = ST_SERVE;
            S_RALLY: code = ST_RALLY;
            default: code = ST_POINT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rally_sequencer_frame_counter.sv
// Frame counter shared by the SERVE and POINT timeouts.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-low reset
//   i_clear         synchronous clear (wins over counting)
//   i_enable        counting allowed
//   i_frame_tick    one-cycle frame pulse; counted when enabled
//   o_count         current count
module rally_sequencer_frame_counter #(
    parameter int CNT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_frame_tick,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && i_frame_tick) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rally_sequencer.sv
// Match-level sequencer for the pong datapath: scores, serve/rally/point/
// game-over flow, ball gating and serve pulses. All outputs are registered.
// Optional feature macro: PAUSE_EN (adds i_pause and start-toggled pause).
// Ports:
//   i_clk, i_reset      clock, asynchronous active-low reset
//   i_frame_tick        one pulse per video frame
//   i_start             debounced level, acted on at its rising edge
//   i_miss_left/right   ball passed left (P2 scores) / right (P1 scores)
//   i_pause             (PAUSE_EN) level, holds play while high
//   o_ball_enable       ball may move
//   o_ball_serve        one-cycle launch pulse on the first RALLY cycle
//   o_serve_dir         0 = toward P1, 1 = toward P2
//   o_score_p1/p2       scores
//   o_game_over         high in OVER; o_winner 0 = P1, 1 = P2
//   o_game_state        IDLE=0 SERVE=1 RALLY=2 POINT/OVER=3
//
// state | meaning
// IDLE  | waiting for start, scores held at 0
// SERVE | counting frames before launch
// RALLY | ball live, waiting for a miss
// POINT | play frozen after a point
// OVER  | match decided, waiting for start to return to IDLE
module rally_sequencer
    import rally_sequencer_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_frame_tick,
    input  logic               i_start,
    input  logic               i_miss_left,
    input  logic               i_miss_right,
`ifdef PAUSE_EN
    input  logic               i_pause,
`endif
    output logic               o_ball_enable,
    output logic               o_ball_serve,
    output logic               o_serve_dir,
    output logic [SCORE_W-1:0] o_score_p1,
    output logic [SCORE_W-1:0] o_score_p2,
    output logic               o_game_over,
    output logic               o_winner,
    output logic [1:0]         o_game_state
);

    localparam int                 CNT_W      = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

    seq_state_t         r_state, w_state_nxt;
    logic               r_start_q;
    logic               r_ball_enable, r_ball_serve, r_serve_dir, r_game_over, r_winner;
    logic [SCORE_W-1:0] r_score_p1, r_score_p2;
    logic [1:0]         r_game_state;

    logic               w_start_rise, w_run, w_play_state, w_hold_nxt;
    logic               w_serve_dir_nxt, w_winner_nxt;
    logic [SCORE_W-1:0] w_score_p1_nxt, w_score_p2_nxt;
    logic               w_cnt_clear, w_cnt_enable;
    logic [CNT_W-1:0]   w_count;

    assign w_start_rise = i_start & ~r_start_q;
    assign w_play_state = (r_state == S_SERVE) || (r_state == S_RALLY) || (r_state == S_POINT);

`ifdef PAUSE_EN
    logic r_paused, w_paused_nxt, w_pause_toggle;

    // The toggle cycle itself is frozen too, so pausing never races a
    // transition and un-pausing resumes on the following cycle.
    assign w_pause_toggle = w_start_rise && w_play_state;
    assign w_run          = !r_paused && !w_pause_toggle && !i_pause;
    assign w_paused_nxt   = (w_state_nxt == S_OVER) ? 1'b0
                          : (w_pause_toggle ? ~r_paused : r_paused);
    assign w_hold_nxt     = w_paused_nxt || i_pause;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_paused <= 1'b0;
        else          r_paused <= w_paused_nxt;
    end
`else
    assign w_run      = 1'b1;
    assign w_hold_nxt = 1'b0;
`endif

    assign w_cnt_clear  = (w_state_nxt != r_state);
    assign w_cnt_enable = w_run && ((r_state == S_SERVE) || (r_state == S_POINT));

    rally_sequencer_frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_cnt_clear),
        .i_enable     (w_cnt_enable),
        .i_frame_tick (i_frame_tick),
        .o_count      (w_count)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_score_p1_nxt  = r_score_p1;
        w_score_p2_nxt  = r_score_p2;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_nxt    = r_winner;
        case (r_state)
            S_IDLE: begin
                w_score_p1_nxt = '0;
                w_score_p2_nxt = '0;
                if (w_start_rise) w_state_nxt = S_SERVE;
            end
            S_SERVE: begin
                if (w_run && i_frame_tick && (w_count == SERVE_LAST)) w_state_nxt = S_RALLY;
            end
            S_RALLY: begin
                if (w_run && (i_miss_left || i_miss_right)) begin
                    w_state_nxt = S_POINT;
                    // Simultaneous misses are a replay: no score, same serve.
                    if (i_miss_right && !i_miss_left) begin
                        if (r_score_p1 < WIN_S) w_score_p1_nxt = r_score_p1 + 1'b1;
                        w_serve_dir_nxt = DIR_P2;
                    end else if (i_miss_left && !i_miss_right) begin
                        if (r_score_p2 < WIN_S) w_score_p2_nxt = r_score_p2 + 1'b1;
                        w_serve_dir_nxt = DIR_P1;
                    end
                end
            end
            S_POINT: begin
                if (w_run && i_frame_tick && (w_count == POINT_LAST)) begin
                    if ((r_score_p1 == WIN_S) || (r_score_p2 == WIN_S)) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = (r_score_p2 == WIN_S);
                    end else begin
                        w_state_nxt = S_SERVE;
                    end
                end
            end
            S_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt    = S_IDLE;
                    w_score_p1_nxt = '0;
                    w_score_p2_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_ball_enable <= 1'b0;
            r_ball_serve  <= 1'b0;
            r_serve_dir   <= 1'b0;
            r_score_p1    <= '0;
            r_score_p2    <= '0;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
            r_game_state  <= ST_IDLE;
        end else begin
            r_state       <= w_state_nxt;
            r_start_q     <= i_start;
            r_ball_enable <= (w_state_nxt == S_RALLY) && !w_hold_nxt;
            r_ball_serve  <= (r_state == S_SERVE) && (w_state_nxt == S_RALLY);
            r_serve_dir   <= w_serve_dir_nxt;
            r_score_p1    <= w_score_p1_nxt;
            r_score_p2    <= w_score_p2_nxt;
            r_game_over   <= (w_state_nxt == S_OVER);
            r_winner      <= w_winner_nxt;
            r_game_state  <= state_code(w_state_nxt);
        end
    end

    assign o_ball_enable = r_ball_enable;
    assign o_ball_serve  = r_ball_serve;
    assign o_serve_dir   = r_serve_dir;
    assign o_score_p1    = r_score_p1;
    assign o_score_p2    = r_score_p2;
    assign o_game_over   = r_game_over;
    assign o_winner      = r_winner;
    assign o_game_state  = r_game_state;

endmodule

// File: tb/tb_rally_sequencer.sv
// Directed bench for rally_sequencer with WIN_SCORE=3, SERVE_FRAMES=3,
// POINT_FRAMES=2 and a frame tick every 10 clocks. Pause checks run when
// PAUSE_EN is defined.
module tb_rally_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, start, miss_left, miss_right;
`ifdef PAUSE_EN
    logic       pause;
`endif
    logic       ball_enable, ball_serve, serve_dir, game_over, winner;
    logic [3:0] score_p1, score_p2;
    logic [1:0] game_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rally_sequencer #(.WIN_SCORE(3), .SERVE_FRAMES(3), .POINT_FRAMES(2)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_frame_tick  (frame_tick),
        .i_start       (start),
        .i_miss_left   (miss_left),
        .i_miss_right  (miss_right),
`ifdef PAUSE_EN
        .i_pause       (pause),
`endif
        .o_ball_enable (ball_enable),
        .o_ball_serve  (ball_serve),
        .o_serve_dir   (serve_dir),
        .o_score_p1    (score_p1),
        .o_score_p2    (score_p2),
        .o_game_over   (game_over),
        .o_winner      (winner),
        .o_game_state  (game_state)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (9) step();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, game_state, 0);
        chk({tag, "_en"},    ball_enable, 0);
        chk({tag, "_serve"}, ball_serve, 0);
        chk({tag, "_dir"},   serve_dir, 0);
        chk({tag, "_p1"},    score_p1, 0);
        chk({tag, "_p2"},    score_p2, 0);
        chk({tag, "_over"},  game_over, 0);
        chk({tag, "_win"},   winner, 0);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0;
`ifdef PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Start and serve into the first rally.
        pulse_start();
        chk("serve_state", game_state, 1);
        frames(2);
        chk("serve_hold", game_state, 1);
        chk("serve_no_pulse", ball_serve, 0);
        frames(1);
        chk("rally_state", game_state, 2);
        chk("rally_serve_pulse", ball_serve, 1);
        chk("rally_dir", serve_dir, 0);
        chk("rally_en", ball_enable, 1);
        step();
        chk("serve_pulse_1cyc", ball_serve, 0);
        chk("rally_en_held", ball_enable, 1);

        // Asynchronous reset in the middle of the rally.
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", game_state, 0);

        pulse_start();
        frames(3);
        chk("rally2_state", game_state, 2);

`ifndef PAUSE_EN
        pulse_start();
        chk("start_ignored_state", game_state, 2);
        chk("start_ignored_en", ball_enable, 1);
`endif

        // P1 scores.
        pulse_miss(1'b0, 1'b1);
        chk("p1pt_score", score_p1, 1);
        chk("p1pt_p2", score_p2, 0);
        chk("p1pt_dir", serve_dir, 1);
        chk("p1pt_en", ball_enable, 0);
        chk("p1pt_state", game_state, 3);
        frames(1);
        chk("point_hold", game_state, 3);
        frames(1);
        chk("point_to_serve", game_state, 1);

        // A miss during SERVE is ignored.
        pulse_miss(1'b1, 1'b0);
        chk("serve_miss_p2", score_p2, 0);
        chk("serve_miss_state", game_state, 1);
        frames(3);
        chk("rally3_dir", serve_dir, 1);

        // Simultaneous misses: replay.
        pulse_miss(1'b1, 1'b1);
        chk("both_state", game_state, 3);
        chk("both_p1", score_p1, 1);
        chk("both_p2", score_p2, 0);
        chk("both_dir", serve_dir, 1);
        frames(2);
        chk("both_serve", game_state, 1);
        frames(3);
        chk("rally4_state", game_state, 2);

`ifdef PAUSE_EN
        pulse_start();
        chk("pause_en", ball_enable, 0);
        chk("pause_state", game_state, 2);
        frames(20);
        pulse_miss(1'b1, 1'b0);
        chk("paused_state", game_state, 2);
        chk("paused_p2", score_p2, 0);
        chk("paused_en", ball_enable, 0);
        pulse_start();
        chk("unpause_en", ball_enable, 1);
        chk("unpause_state", game_state, 2);
`endif

        // P2 takes three straight points and the match.
        for (int p = 1; p <= 3; p++) begin
            pulse_miss(1'b1, 1'b0);
            chk("p2pt_score", score_p2, p);
            chk("p2pt_dir", serve_dir, 0);
            frames(2);
            if (p < 3) frames(3);
        end
        chk("over_state", game_state, 3);
        chk("over_flag", game_over, 1);
        chk("over_winner", winner, 1);
        chk("over_en", ball_enable, 0);
        chk("over_p1", score_p1, 1);
        pulse_miss(1'b1, 1'b0);
        frames(1);
        chk("over_miss_p2", score_p2, 3);
        chk("over_hold", game_state, 3);
        pulse_start();
        chk("restart_state", game_state, 0);
        chk("restart_p1", score_p1, 0);
        chk("restart_p2", score_p2, 0);
        chk("restart_over", game_over, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
